// File: rtl/audio_codec_tdm.sv
// Master-mode I2S / left-justified / TDM serial audio port with a valid/ready frame handshake.
// Optional AUD_LOOPBACK_EN adds a loopback input that feeds the DAC stream back into capture.
module audio_codec_tdm #(
   parameter int unsigned SAMPLE_W  = 16,
   parameter int unsigned SLOT_W    = 32,
   parameter int unsigned NUM_SLOTS = 2,
   parameter int unsigned BCLK_DIV  = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          enable,
   input  logic                          fmt_lj,
   input  logic [NUM_SLOTS*SAMPLE_W-1:0] tx_data,
   input  logic                          tx_valid,
   output logic                          tx_ready,
   output logic [NUM_SLOTS*SAMPLE_W-1:0] rx_data,
   output logic                          rx_valid,
   output logic                          underrun,
   output logic                          aud_bclk,
   output logic                          aud_lrck,
   output logic                          aud_dacdat,
   input  logic                          aud_adcdat
`ifdef AUD_LOOPBACK_EN
   ,
   input  logic                          loopback
`endif
);

   localparam int unsigned FW    = NUM_SLOTS * SAMPLE_W;
   localparam int unsigned FRAME = NUM_SLOTS * SLOT_W;
   localparam int unsigned HALF  = BCLK_DIV / 2;
   localparam int unsigned CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int unsigned B_W   = (FRAME > 1) ? $clog2(FRAME) : 1;

   typedef enum logic [0:0] {StIdle, StRun} state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [B_W-1:0]    b_q;
   logic              fmt_q;
   logic              armed_q;
   logic [FW-1:0]     frame_q;
   logic [FW-1:0]     rx_shift_q;

   logic              tick, fall, rise, frame_end, start, load, fmt_next, dac_next, adc_in;
   logic              cap_hit, cap_last;
   int unsigned       b_int, b_next, cap_d, cap_k, cap_pos;
   logic [FW-1:0]     frame_next, rx_next;

   // Frame position of the data bit on the wire while bit counter is b; I2S lags by one BCLK.
   function automatic int unsigned data_idx(input int unsigned b, input logic lj);
      if (lj) return b;
      else if (b == 0) return FRAME - 1;
      else return b - 1;
   endfunction

   function automatic logic frame_bit(input logic [FW-1:0] f, input int unsigned d);
      int unsigned k;
      logic [FW-1:0] sh;
      k = d % SLOT_W;
      if (k >= SAMPLE_W) return 1'b0;
      sh = f >> ((d / SLOT_W) * SAMPLE_W + SAMPLE_W - 1 - k);
      return sh[0];
   endfunction

   function automatic logic lrck_fn(input int unsigned b, input logic lj);
      if (NUM_SLOTS == 2) return lj ? (b >= SLOT_W) : (((b + 1) % FRAME) >= SLOT_W);
      else return lj ? (b == 0) : (b == FRAME - 1);
   endfunction

`ifdef AUD_LOOPBACK_EN
   assign adc_in = loopback ? aud_dacdat : aud_adcdat;
`else
   assign adc_in = aud_adcdat;
`endif

   always_comb begin
      b_int      = 32'(b_q);
      tick       = (state_q == StRun) && (cnt_q == CNT_W'(HALF - 1));
      fall       = tick && aud_bclk;
      rise       = tick && !aud_bclk;
      frame_end  = fall && (b_int == FRAME - 1);
      start      = (state_q == StIdle) && enable;
      load       = reset_n && (start || (frame_end && enable));
      frame_next = tx_valid ? tx_data : frame_q;
      b_next     = frame_end ? 0 : b_int + 1;
      fmt_next   = frame_end ? fmt_lj : fmt_q;
      // At the wrap an I2S stream still owes the previous frame's last bit, so read the old buffer.
      dac_next   = frame_bit((frame_end && fmt_next) ? frame_next : frame_q,
                             data_idx(b_next, fmt_next));
      cap_d      = data_idx(b_int, fmt_q);
      cap_k      = cap_d % SLOT_W;
      cap_hit    = rise && (cap_k < SAMPLE_W);
      cap_last   = cap_hit && (cap_d / SLOT_W == NUM_SLOTS - 1) && (cap_k == SAMPLE_W - 1);
      cap_pos    = 0;
      if (cap_hit) cap_pos = (cap_d / SLOT_W) * SAMPLE_W + SAMPLE_W - 1 - cap_k;
      rx_next    = (rx_shift_q & ~(FW'(1) << cap_pos)) | (FW'(adc_in) << cap_pos);
   end

   assign tx_ready = load;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         cnt_q      <= '0;
         b_q        <= '0;
         fmt_q      <= 1'b0;
         armed_q    <= 1'b0;
         frame_q    <= '0;
         rx_shift_q <= '0;
         rx_data    <= '0;
         rx_valid   <= 1'b0;
         underrun   <= 1'b0;
         aud_bclk   <= 1'b0;
         aud_lrck   <= 1'b0;
         aud_dacdat <= 1'b0;
      end else begin
         rx_valid <= 1'b0;
         if (load) begin
            frame_q <= frame_next;
            if (!tx_valid) underrun <= 1'b1;
         end
         unique case (state_q)
            StIdle: begin
               if (enable) begin
                  state_q    <= StRun;
                  cnt_q      <= '0;
                  b_q        <= '0;
                  fmt_q      <= fmt_lj;
                  armed_q    <= 1'b0;
                  aud_bclk   <= 1'b0;
                  aud_lrck   <= lrck_fn(0, fmt_lj);
                  aud_dacdat <= fmt_lj ? frame_bit(frame_next, 0) : 1'b0;
               end
            end
            StRun: begin
               cnt_q <= tick ? '0 : cnt_q + 1'b1;
               if (tick) aud_bclk <= !aud_bclk;
               if (cap_hit) begin
                  rx_shift_q <= rx_next;
                  if (cap_d == 0) armed_q <= 1'b1;
                  // Frames whose first bit preceded the start are never reported.
                  if (cap_last && armed_q) begin
                     rx_valid <= 1'b1;
                     rx_data  <= rx_next;
                  end
               end
               if (fall) begin
                  if (frame_end && !enable) begin
                     state_q    <= StIdle;
                     b_q        <= '0;
                     aud_lrck   <= 1'b0;
                     aud_dacdat <= 1'b0;
                  end else begin
                     b_q        <= B_W'(b_next);
                     fmt_q      <= fmt_next;
                     aud_lrck   <= lrck_fn(b_next, fmt_next);
                     aud_dacdat <= dac_next;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_codec_tdm.sv
// Randomised bench for audio_codec_tdm: a stereo and a 4-slot TDM instance share stimulus and are
// checked every clk against a model that derives pins from elapsed clk count and frame arithmetic.
module tb_audio_codec_tdm;

   localparam int DIV   = 4;
   localparam int HALF  = DIV / 2;
   localparam int FRAME = 64;
   localparam int FB    = FRAME * DIV;
   localparam int SW1 = 16, SL1 = 32, NS1 = 2;
   localparam int SW2 = 16, SL2 = 16, NS2 = 4;

   logic        clk = 1'b0;
   logic        reset_n, enable, fmt_lj, tx_valid, adc1, adc2;
   logic [63:0] tx_data;
   logic        tr1, tr2, rv1, rv2, ur1, ur2, bclk1, bclk2, lr1, lr2, dac1, dac2;
   logic [31:0] rx1;
   logic [63:0] rx2;

   int          n_checks = 0;
   int          n_fail = 0;
   logic        ur_exp;
   logic [31:0] rx_exp1;
   logic [63:0] rx_exp2;

   always #5 clk = ~clk;

   audio_codec_tdm #(.SAMPLE_W(SW1), .SLOT_W(SL1), .NUM_SLOTS(NS1), .BCLK_DIV(DIV)) dut_st (
      .clk(clk), .reset_n(reset_n), .enable(enable), .fmt_lj(fmt_lj),
      .tx_data(tx_data[31:0]), .tx_valid(tx_valid), .tx_ready(tr1),
      .rx_data(rx1), .rx_valid(rv1), .underrun(ur1),
      .aud_bclk(bclk1), .aud_lrck(lr1), .aud_dacdat(dac1), .aud_adcdat(adc1)
`ifdef AUD_LOOPBACK_EN
      , .loopback(1'b0)
`endif
   );

   audio_codec_tdm #(.SAMPLE_W(SW2), .SLOT_W(SL2), .NUM_SLOTS(NS2), .BCLK_DIV(DIV)) dut_tdm (
      .clk(clk), .reset_n(reset_n), .enable(enable), .fmt_lj(fmt_lj),
      .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tr2),
      .rx_data(rx2), .rx_valid(rv2), .underrun(ur2),
      .aud_bclk(bclk2), .aud_lrck(lr2), .aud_dacdat(dac2), .aud_adcdat(adc2)
`ifdef AUD_LOOPBACK_EN
      , .loopback(1'b0)
`endif
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   // Sample bit carried by frame position d (MSB first, zero padding after SAMPLE_W bits).
   function automatic logic data_bit(input logic [63:0] fr, input int sw, input int slw,
                                     input int d);
      int k;
      logic [63:0] sh;
      if (d < 0) return 1'b0;
      k = d % slw;
      if (k >= sw) return 1'b0;
      sh = fr >> ((d / slw) * sw + sw - 1 - k);
      return sh[0];
   endfunction

   function automatic logic lrck_exp(input int b, input logic lj, input int slw, input int ns);
      if (ns == 2) return lj ? (b >= slw) : (((b + 1) % FRAME) >= slw);
      return lj ? (b == 0) : (b == FRAME - 1);
   endfunction

   // Runs nfr frames in one format; frame 'bad' is offered without tx_valid; enable drops at b=10
   // of the last frame, so the port must finish that frame and then go quiet.
   task automatic run(input logic lj, input int nfr, input int bad);
      logic [63:0] raw [8];
      logic [63:0] txf [8];
      logic [63:0] adcf [8];
      logic        vld [8];
      int          stop_n, drop_n, s, p, b, q, g, d, r, k, dl1, dl2;
      logic        run_on, bclk_e, tr_e, rv1_e, rv2_e;
      for (int i = 0; i < 8; i++) begin
         raw[i]  = {$urandom, $urandom};
         adcf[i] = {$urandom, $urandom};
         vld[i]  = (i != bad);
         if (vld[i] || i == 0) txf[i] = raw[i];
         else txf[i] = txf[i-1];
      end
      s      = lj ? 0 : 1;
      stop_n = nfr * FB;
      drop_n = ((nfr - 1) * FRAME + 10) * DIV;
      dl1    = (NS1 - 1) * SL1 + SW1 - 1;
      dl2    = (NS2 - 1) * SL2 + SW2 - 1;
      @(negedge clk);
      fmt_lj = lj; enable = 1'b1; tx_valid = vld[0]; tx_data = raw[0]; adc1 = 1'b0; adc2 = 1'b0;
      #1 check("tx_ready_start", 64'({tr1, tr2}), 64'(2'b11));
      for (int n = 0; n < stop_n + 4 * DIV; n++) begin
         @(posedge clk);
         #1;
         p = n / DIV;
         b = p % FRAME;
         q = p - s;
         if (q >= 0) begin g = q / FRAME; d = q % FRAME; end
         else begin g = 0; d = -1; end
         k = n / FB;
         if (n == drop_n) enable = 1'b0;
         if (n % FB == 0 && k < nfr && !vld[k]) ur_exp = 1'b1;
         if (n % FB == 0 && k + 1 < 8) begin
            tx_valid = vld[k+1];
            tx_data  = raw[k+1];
         end
         adc1 = data_bit(adcf[g], SW1, SL1, d);
         adc2 = data_bit(adcf[g], SW2, SL2, d);
         #1;
         run_on = n < stop_n;
         bclk_e = run_on && ((n % DIV) >= HALF);
         tr_e   = ((n + 1) % FB == 0) && (n + 1 < stop_n);
         rv1_e  = 1'b0;
         rv2_e  = 1'b0;
         if (run_on && n >= HALF && (n - HALF) % DIV == 0) begin
            r = p - s - dl1;
            if (r >= 0 && r % FRAME == 0) begin rv1_e = 1'b1; rx_exp1 = adcf[r/FRAME][31:0]; end
            r = p - s - dl2;
            if (r >= 0 && r % FRAME == 0) begin rv2_e = 1'b1; rx_exp2 = adcf[r/FRAME]; end
         end
         check("pins_stereo", 64'({bclk1, lr1, dac1, tr1, rv1, ur1}),
               64'({bclk_e, run_on && lrck_exp(b, lj, SL1, NS1),
                    run_on && data_bit(txf[g], SW1, SL1, d), tr_e, rv1_e, ur_exp}));
         check("pins_tdm", 64'({bclk2, lr2, dac2, tr2, rv2, ur2}),
               64'({bclk_e, run_on && lrck_exp(b, lj, SL2, NS2),
                    run_on && data_bit(txf[g], SW2, SL2, d), tr_e, rv2_e, ur_exp}));
         check("rx_stereo", 64'(rx1), 64'(rx_exp1));
         check("rx_tdm", rx2, rx_exp2);
      end
   endtask

   initial begin
      reset_n = 1'b0; enable = 1'b0; fmt_lj = 1'b0; tx_valid = 1'b0; tx_data = '0;
      adc1 = 1'b0; adc2 = 1'b0; ur_exp = 1'b0; rx_exp1 = '0; rx_exp2 = '0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_pins_stereo", 64'({bclk1, lr1, dac1, tr1, rv1, ur1}), 64'(0));
      check("reset_pins_tdm", 64'({bclk2, lr2, dac2, tr2, rv2, ur2}), 64'(0));
      check("reset_rx", rx2 | 64'(rx1), 64'(0));
      @(negedge clk) reset_n = 1'b1;

      run(1'b1, 3, -1);
      run(1'b0, 4, 2);

      repeat (10) @(posedge clk);
      #1;
      check("underrun_sticky", 64'({ur1, ur2}), 64'(2'b11));
      check("idle_pins", 64'({bclk1, lr1, dac1, bclk2, lr2, dac2}), 64'(0));
      @(negedge clk) reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("underrun_cleared", 64'({ur1, ur2}), 64'(0));
      check("rx_cleared", rx2 | 64'(rx1), 64'(0));

      // Reset mid-frame: everything must return to reset values at once.
      @(negedge clk);
      reset_n = 1'b1; enable = 1'b1; fmt_lj = 1'b1; tx_valid = 1'b1; tx_data = {$urandom, $urandom};
      repeat (150) @(posedge clk);
      @(negedge clk) reset_n = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("midreset_pins", 64'({bclk1, lr1, dac1, tr1, rv1, ur1, bclk2, lr2, dac2, tr2, rv2, ur2}),
               64'(0));
      end
      check("midreset_rx", rx2 | 64'(rx1), 64'(0));
      enable = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
